// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 8N1 UART receiver with bit-centre sampling, false-start rejection
// and stop-bit (framing) error detection.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit after D7
// (even parity, or odd when PARITY_ODD=1) and drives parity_err.
module uart_rx #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int CLKS_PER_BIT = CLK_HZ / BAUD
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // Last count of a full bit period and of the half period to the start-bit centre.
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t           state_q;
  logic             sync1_q;
  logic             rx_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             full_done;
  logic             half_done;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q;
  logic             parity_err_q;
`endif

  assign full_done = (cnt_q == FULL_LAST);
  assign half_done = (cnt_q == HALF_LAST);

  // Two-flop synchronizer for the asynchronous line; resets to the idle (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      rx_s_q  <= sync1_q;
    end
  end

  // Receive FSM: bit timing, shift register and registered one-cycle strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
          end
        end
        S_START: begin
          if (half_done) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            // A line back high at the start-bit centre was only a glitch.
            state_q   <= rx_s_q ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (full_done) begin
            cnt_q   <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (full_done) begin
            cnt_q     <= '0;
            par_bad_q <= (^shift_q) ^ rx_s_q ^ PARITY_ODD;
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (full_done) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err_q <= par_bad_q;
`endif
              // Leaving at the stop-bit centre leaves half a bit to catch the next start.
              state_q <= S_IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          // Hold off through a break so it reports only one framing error.
          if (rx_s_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed bench for uart_rx at 32 clocks per bit.
module tb_uart_rx;

  localparam int  CPB      = 32;
  localparam real BIT_NOM  = 320.0;   // 32 cycles of 10 ns
  localparam real BIT_SLOW = 329.6;   // sender 3% slow
  localparam real BIT_FAST = 310.4;   // sender 3% fast
`ifdef UART_RX_PARITY_EN
  localparam int  LAT      = 2 + CPB/2 + 9*CPB + 2 + CPB;
  localparam int  EXP_PE   = 1;
`else
  localparam int  LAT      = 2 + CPB/2 + 9*CPB + 2;
  localparam int  EXP_PE   = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int total = 0;
  int bad   = 0;

  int valid_cnt = 0;
  int fe_cnt    = 0;
  int pe_cnt    = 0;
  int both_cnt  = 0;
  logic [7:0] rx_log[$];

`ifdef UART_RX_PARITY_EN
  logic flip_par = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       stop;
    real        bns;
    int         idle_bits;
    int         exp_valid;
    int         exp_fe;
    logic [7:0] exp_dout;
  } vec_t;

  vec_t vecs[8];

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Output monitor, sampled 1 ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (valid) begin
      valid_cnt++;
      rx_log.push_back(data_out);
    end
    if (frame_err) fe_cnt++;
    if (parity_err) pe_cnt++;
    if (frame_err && (valid || parity_err)) both_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input real bns);
    rx = 1'b0;
    #(bns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bns);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ flip_par;
    #(bns);
`endif
    rx = stop;
    #(bns);
  endtask

  task automatic idle(input int n, input real bns);
    rx = 1'b1;
    #(n * bns);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int v0, f0, lat, busy_low, base, busy_seen;
    logic got;
    logic [7:0] exp_b;

    vecs[0] = '{8'hFF, 1'b1, BIT_SLOW, 2, 1, 0, 8'hFF};
    vecs[1] = '{8'h00, 1'b1, BIT_SLOW, 2, 1, 0, 8'h00};
    vecs[2] = '{8'h55, 1'b1, BIT_FAST, 2, 1, 0, 8'h55};
    vecs[3] = '{8'hA5, 1'b0, BIT_NOM,  2, 0, 1, 8'h55};
    vecs[4] = '{8'h3C, 1'b1, BIT_NOM,  2, 1, 0, 8'h3C};
    vecs[5] = '{8'h81, 1'b1, BIT_FAST, 2, 1, 0, 8'h81};
    vecs[6] = '{8'h7E, 1'b1, BIT_SLOW, 2, 1, 0, 8'h7E};
    vecs[7] = '{8'hC3, 1'b0, BIT_SLOW, 2, 0, 1, 8'h7E};

    // Reset state.
    repeat (4) @(posedge clk);
    #1;
    check("rst_data_out", data_out, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    idle(2, BIT_NOM);
    $display("txn reset: outputs checked");

    // First frame: latency window and busy across the whole frame.
    @(posedge clk);
    #1;
    v0 = valid_cnt;
    lat = 0; busy_low = 0; got = 1'b0;
    fork
      begin
        send_frame(8'h41, 1'b1, BIT_NOM);
        idle(1, BIT_NOM);
      end
      begin
        while (!got && lat < 2000) begin
          @(posedge clk);
          #1;
          lat++;
          if (valid) got = 1'b1;
          else if (lat >= 3 && !busy) busy_low++;
        end
      end
    join
    total++;
    if (!got || lat < LAT - 2 || lat > LAT + 2) begin
      bad++;
      $display("FAIL first_latency: got %0d cycles (seen=%0d) required %0d..%0d", lat, got, LAT - 2, LAT + 2);
    end
    check("first_busy_low_cycles", busy_low, 0);
    settle();
    check("first_data", data_out, 8'h41);
    check("first_valid_count", valid_cnt - v0, 1);
    $display("txn first 0x41: latency=%0d", lat);

    // Zero-gap loopback stream 0x41..0x57 then 0x41.
    base = rx_log.size();
    f0 = fe_cnt;
    for (int i = 0; i < 24; i++) begin
      exp_b = (i == 23) ? 8'h41 : 8'(8'h41 + i);
      send_frame(exp_b, 1'b1, BIT_NOM);
    end
    idle(2, BIT_NOM);
    settle();
    check("stream_count", rx_log.size() - base, 24);
    check("stream_frame_err", fe_cnt - f0, 0);
    for (int i = 0; i < 24 && base + i < rx_log.size(); i++) begin
      exp_b = (i == 23) ? 8'h41 : 8'(8'h41 + i);
      check("stream_byte", rx_log[base + i], exp_b);
    end
    $display("txn stream: %0d bytes", rx_log.size() - base);

    // Table-driven frames at nominal and +/-3% rates, good and bad stop bits.
    for (int k = 0; k < 8; k++) begin
      v0 = valid_cnt;
      f0 = fe_cnt;
      send_frame(vecs[k].data, vecs[k].stop, vecs[k].bns);
      idle(vecs[k].idle_bits, vecs[k].bns);
      settle();
      check("vec_valid", valid_cnt - v0, vecs[k].exp_valid);
      check("vec_frame_err", fe_cnt - f0, vecs[k].exp_fe);
      check("vec_data_out", data_out, vecs[k].exp_dout);
      $display("txn vec %0d: data=0x%02h stop=%0d bit_ns=%0.1f -> data_out=0x%02h",
               k, vecs[k].data, vecs[k].stop, vecs[k].bns, data_out);
    end

    // Short low glitch on an idle line is rejected at the start-bit check.
    v0 = valid_cnt; f0 = fe_cnt; busy_seen = 0;
    @(posedge clk);
    #1;
    rx = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 9) rx = 1'b1;
      if (busy) busy_seen = 1;
    end
    check("glitch_busy_seen", busy_seen, 1);
    check("glitch_busy_end", busy, 0);
    check("glitch_valid", valid_cnt - v0, 0);
    check("glitch_frame_err", fe_cnt - f0, 0);
    $display("txn glitch: rejected");

    // Bad stop bit followed by a 20-bit break: exactly one framing error.
    v0 = valid_cnt; f0 = fe_cnt;
    send_frame(8'hA5, 1'b0, BIT_NOM);
    #(20 * BIT_NOM);
    @(posedge clk);
    #1;
    check("break_busy_held", busy, 1);
    check("break_frame_err", fe_cnt - f0, 1);
    check("break_valid", valid_cnt - v0, 0);
    check("break_data_kept", data_out, 8'h7E);
    idle(2, BIT_NOM);
    settle();
    check("break_busy_released", busy, 0);
    check("break_frame_err_once", fe_cnt - f0, 1);
    send_frame(8'h3C, 1'b1, BIT_NOM);
    idle(2, BIT_NOM);
    settle();
    check("after_break_data", data_out, 8'h3C);
    check("after_break_valid", valid_cnt - v0, 1);
    $display("txn break: frame_err=%0d then 0x%02h", fe_cnt - f0, data_out);

    // Reset pulse in the middle of data bit 4 aborts the frame.
    @(posedge clk);
    #1;
    v0 = valid_cnt; f0 = fe_cnt;
    rx = 1'b0;
    #(5.5 * BIT_NOM);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    check("midrst_frame_err", frame_err, 0);
    @(negedge clk) rst = 1'b0;
    idle(12, BIT_NOM);
    check("midrst_no_strobe", (valid_cnt - v0) + (fe_cnt - f0), 0);
    send_frame(8'h5A, 1'b1, BIT_NOM);
    idle(2, BIT_NOM);
    settle();
    check("after_rst_data", data_out, 8'h5A);
    check("after_rst_valid", valid_cnt - v0, 1);
    $display("txn midframe reset: then 0x%02h", data_out);

`ifdef UART_RX_PARITY_EN
    // 0x07 has odd weight, so even parity needs 1; sending 0 must flag parity_err.
    v0 = valid_cnt;
    flip_par = 1'b1;
    send_frame(8'h07, 1'b1, BIT_NOM);
    flip_par = 1'b0;
    idle(2, BIT_NOM);
    settle();
    check("par_valid", valid_cnt - v0, 1);
    check("par_data", data_out, 8'h07);
    $display("txn parity: 0x07 with wrong parity bit");
`endif

    check("strobe_overlap", both_cnt, 0);
    check("parity_err_count", pe_cnt, EXP_PE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
